// File: rtl/rv_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package rv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam int unsigned FETCH_DEPTH = 2;
    // Fetch PC leads the delivered instruction PC by this many bytes.
    localparam logic [31:0] PC_LEAD     = 32'(FETCH_DEPTH) * INSTR_BYTES;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pipe_reg.sv
// One fetch pipeline stage: payload + valid with reset, flush and hold.
module fetch_pipe_reg #(
    parameter int            W         = 32,
    parameter logic [W-1:0]  FLUSH_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] d_payload,
    input  logic         d_valid,
    output logic [W-1:0] q_payload,
    output logic         q_valid
);

    // An invalid slot always carries FLUSH_VAL so bubbles never leak stale data.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            q_payload <= FLUSH_VAL;
            q_valid   <= 1'b0;
        end else if (!hold) begin
            q_payload <= d_valid ? d_payload : FLUSH_VAL;
            q_valid   <= d_valid;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, 2-deep fetch pipe, redirect/halt
// handling and redirect/squash performance counters.
module pc_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic [31:0]      imem_addr,
    output logic             imem_en,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic [31:0]      instr_pc,
    output logic             instr_valid,
    output logic [31:0]      fetch_pc,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [31:0]    pc_reg;
    logic [31:0]    f1_pc;
    logic           f1_valid;
    logic           stall;
    logic [1:0]     squash_inc;
    logic [CNT_W:0] squash_sum;

    // Redirect overrides halt on the same edge.
    assign stall     = halt && !redirect_en;
    assign fetch_pc  = pc_reg;
    assign imem_en   = !reset;
    // While halted, re-read the F1 address so rdata matches F1 on release.
    assign imem_addr = halt ? f1_pc : pc_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (redirect_en) begin
            pc_reg <= align_pc(redirect_pc);
        end else if (!halt) begin
            pc_reg <= pc_reg + INSTR_BYTES;
        end
    end

    fetch_pipe_reg #(
        .W         (32),
        .FLUSH_VAL (32'h0000_0000)
    ) u_f1 (
        .clock     (clock),
        .reset     (reset),
        .hold      (stall),
        .flush     (redirect_en),
        .d_payload (pc_reg),
        .d_valid   (1'b1),
        .q_payload (f1_pc),
        .q_valid   (f1_valid)
    );

    fetch_pipe_reg #(
        .W         (64),
        .FLUSH_VAL ({NOP_INSTR, 32'h0000_0000})
    ) u_d (
        .clock     (clock),
        .reset     (reset),
        .hold      (stall),
        .flush     (redirect_en),
        .d_payload ({imem_rdata, f1_pc}),
        .d_valid   (f1_valid),
        .q_payload ({instr_out, instr_pc}),
        .q_valid   (instr_valid)
    );

    assign squash_inc = {1'b0, f1_valid} + {1'b0, instr_valid};
    assign squash_sum = {1'b0, squash_cnt} + {{(CNT_W-1){1'b0}}, squash_inc};

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_err <= 1'b0;
            redirect_cnt <= '0;
            squash_cnt   <= '0;
        end else if (redirect_en) begin
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
            redirect_cnt <= redirect_cnt + 1'b1;
            squash_cnt   <= squash_sum[CNT_W] ? '1 : squash_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; a second instance with 2-bit counters covers
// counter wrap and saturation.
module tb_pc_fetch;

    logic        clock;
    logic        reset;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] fetch_pc;
    logic        misalign_err;
    logic [15:0] redirect_cnt;
    logic [15:0] squash_cnt;

    logic [31:0] s_imem_addr;
    logic        s_imem_en;
    logic [31:0] s_instr_out;
    logic [31:0] s_instr_pc;
    logic        s_instr_valid;
    logic [31:0] s_fetch_pc;
    logic        s_misalign_err;
    logic [1:0]  s_redirect_cnt;
    logic [1:0]  s_squash_cnt;

    int checks = 0;
    int errors = 0;

    pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .fetch_pc     (fetch_pc),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt),
        .squash_cnt   (squash_cnt)
    );

    pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_small (
        .clock        (clock),
        .reset        (reset),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .imem_addr    (s_imem_addr),
        .imem_en      (s_imem_en),
        .imem_rdata   (imem_rdata),
        .instr_out    (s_instr_out),
        .instr_pc     (s_instr_pc),
        .instr_valid  (s_instr_valid),
        .fetch_pc     (s_fetch_pc),
        .misalign_err (s_misalign_err),
        .redirect_cnt (s_redirect_cnt),
        .squash_cnt   (s_squash_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: word at address A reads back as 0x1000_0000 + A.
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + imem_addr;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_stream(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_instr"}, instr_out, 32'h1000_0000 + pc);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_nop"}, instr_out, 32'h0000_0013);
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] rc, input logic [15:0] sq);
        chk({tag, "_redirect_cnt"}, {16'b0, redirect_cnt}, {16'b0, rc});
        chk({tag, "_squash_cnt"}, {16'b0, squash_cnt}, {16'b0, sq});
    endtask

    initial begin
        reset       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        tick();
        tick();
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk_bubble("rst");
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
        chk_cnt("rst", 16'd0, 16'd0);

        // Reset release: first valid instruction two edges later.
        reset = 1'b0;
        #1;
        chk("rel_imem_en", {31'b0, imem_en}, 32'd1);
        tick();
        chk_bubble("rel_e1");
        chk("rel_e1_fetch_pc", fetch_pc, 32'h4);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_stream("seq", 32'(4 * i));
            chk("seq_fetch_pc", fetch_pc, 32'(4 * i + 8));
        end

        // Redirect to 0x100 with F1 and D both valid.
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_en = 1'b0;
        chk_bubble("rd1");
        chk("rd1_fetch_pc", fetch_pc, 32'h100);
        chk_cnt("rd1", 16'd1, 16'd2);
        chk("rd1_small_rc", {30'b0, s_redirect_cnt}, 32'd1);
        chk("rd1_small_sq", {30'b0, s_squash_cnt}, 32'd2);
        tick();
        chk_bubble("rd1_e2");
        tick();
        chk_stream("rd1_tgt", 32'h100);

        // Redirect to 0x20, then halt 3 cycles with D at 0x20.
        redirect_en = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect_en = 1'b0;
        chk_cnt("rd2", 16'd2, 16'd4);
        chk("rd2_small_sq_sat", {30'b0, s_squash_cnt}, 32'd3);
        tick();
        tick();
        chk_stream("pre_halt", 32'h20);
        halt = 1'b1;
        #1;
        chk("halt_imem_addr", imem_addr, 32'h24);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_stream("halt", 32'h20);
            chk("halt_fetch_pc", fetch_pc, 32'h28);
            chk("halt_imem_addr", imem_addr, 32'h24);
        end
        halt = 1'b0;
        tick();
        chk_stream("post_halt1", 32'h24);
        chk("post_halt1_fetch_pc", fetch_pc, 32'h2C);
        tick();
        chk_stream("post_halt2", 32'h28);

        // Halt and redirect together: redirect wins.
        halt        = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h40;
        tick();
        halt        = 1'b0;
        redirect_en = 1'b0;
        chk("hr_fetch_pc", fetch_pc, 32'h40);
        chk_bubble("hr");
        chk_cnt("hr", 16'd3, 16'd6);
        tick();
        tick();
        chk_stream("hr_tgt", 32'h40);

        // Misaligned redirect target is aligned down and flagged.
        redirect_en = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_en = 1'b0;
        chk("mis_fetch_pc", fetch_pc, 32'h100);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk_cnt("mis", 16'd4, 16'd8);
        tick();
        tick();
        chk_stream("mis_tgt", 32'h100);
        chk("mis_err_sticky", {31'b0, misalign_err}, 32'd1);

        // PC wrap past 0xFFFF_FFFC.
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 1'b0;
        chk("wrap_fetch_pc0", fetch_pc, 32'hFFFF_FFFC);
        chk_cnt("wrap", 16'd5, 16'd10);
        chk("wrap_small_rc", {30'b0, s_redirect_cnt}, 32'd1);
        chk("wrap_small_sq", {30'b0, s_squash_cnt}, 32'd3);
        tick();
        chk("wrap_fetch_pc1", fetch_pc, 32'h0);
        tick();
        chk_stream("wrap_tgt", 32'hFFFF_FFFC);
        chk("wrap_fetch_pc2", fetch_pc, 32'h4);
        chk("wrap_err_sticky", {31'b0, misalign_err}, 32'd1);

        // Back-to-back redirects: the later one is delivered.
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect_en = 1'b0;
        chk("b2b_fetch_pc", fetch_pc, 32'h300);
        chk_cnt("b2b", 16'd7, 16'd12);
        chk("b2b_small_rc", {30'b0, s_redirect_cnt}, 32'd3);
        tick();
        chk_bubble("b2b_e1");
        tick();
        chk_stream("b2b_tgt", 32'h300);

        // Reset mid-operation clears everything.
        reset = 1'b1;
        tick();
        chk("rst2_fetch_pc", fetch_pc, 32'h0);
        chk_bubble("rst2");
        chk("rst2_misalign", {31'b0, misalign_err}, 32'd0);
        chk_cnt("rst2", 16'd0, 16'd0);
        reset = 1'b0;
        tick();
        tick();
        chk_stream("rst2_tgt", 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
